// File: rtl/vga_text_arbiter_if.sv
// CPU-side request/response bundle for the text-RAM arbiter.
// The master drives a level request held until cpu_ack; the slave answers
// with a one-cycle ack and read data valid alongside it.
interface vga_text_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [8:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;

  modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  input  cpu_ack, cpu_rdata);
  modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  output cpu_ack, cpu_rdata);
endinterface

// File: rtl/vga_text_arbiter.sv
// Single-port text-RAM scheduler for the 32x16-cell console.
// One display prefetch per cell (fixed x_lo slot), remaining cycles shared
// with an optional screen-clear engine and the CPU bus.
// Optional feature macro: VGA_TEXT_CLEAR_EN (hardware screen clear).
module vga_text_arbiter #(
  parameter int FETCH_X   = 8,
  parameter int H_LAST_HI = 41,
  parameter int H_LAST_LO = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          x_hi,
  input  logic [4:0]          x_lo,
  input  logic [4:0]          y_hi,
  vga_text_arbiter_if.slave   bus,
  output logic [8:0]          ram_addr,
  output logic                ram_we,
  output logic [7:0]          ram_wdata,
  input  logic [7:0]          ram_rdata,
  output logic [7:0]          char_code,
  input  logic                clr_start,
  input  logic [7:0]          clr_fill,
  output logic                clr_busy
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t     state;
  logic       rd_q;
  logic [7:0] rdata_q;
  logic [8:0] ram_addr_q;
  logic       disp_pend;
  logic [7:0] char_next;
  logic       disp_slot, col_adv, cpu_grant, clr_grant;
  logic [8:0] disp_addr;
  logic [8:0] clr_cnt;
  logic [7:0] clr_val;

  // Fixed prefetch slot per visible cell, plus the partial last column which
  // prefetches column 0 of the next line (y_hi already advanced at hsync).
  assign disp_slot = rst_n && (x_lo == 5'(FETCH_X)) && !y_hi[4] &&
                     ((x_hi < 6'd31) || (x_hi == 6'(H_LAST_HI)));
  assign disp_addr = (x_hi < 6'd31) ? {y_hi[3:0], x_hi[4:0] + 5'd1}
                                    : {y_hi[3:0], 5'd0};
  assign col_adv   = !y_hi[4] &&
                     (((x_lo == 5'd31) && (x_hi < 6'd31)) ||
                      ((x_hi == 6'(H_LAST_HI)) && (x_lo == 5'(H_LAST_LO))));

`ifdef VGA_TEXT_CLEAR_EN
  logic clr_busy_q;

  assign clr_busy  = clr_busy_q;
  assign clr_grant = rst_n && clr_busy_q && !disp_slot;

  // Clear engine: walk 0..511 on every cycle the display does not own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_busy_q <= 1'b0;
      clr_cnt    <= '0;
      clr_val    <= '0;
    end else if (clr_grant) begin
      clr_cnt <= clr_cnt + 9'd1;
      if (clr_cnt == 9'h1FF) clr_busy_q <= 1'b0;
    end else if (clr_start && !clr_busy_q) begin
      clr_busy_q <= 1'b1;
      clr_cnt    <= '0;
      clr_val    <= clr_fill;
    end
  end
`else
  logic unused_clr;

  assign unused_clr = ^{clr_start, clr_fill};
  assign clr_busy   = 1'b0;
  assign clr_grant  = 1'b0;
  assign clr_cnt    = '0;
  assign clr_val    = '0;
`endif

  // CPU only gets leftover cycles and never while a clear is in flight.
  assign cpu_grant = rst_n && (state == IDLE) && bus.cpu_req &&
                     !disp_slot && !clr_busy;

  // Port mux: display > clear > CPU; idle cycles hold the last address.
  always_comb begin
    ram_addr  = ram_addr_q;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (disp_slot) begin
      ram_addr = disp_addr;
    end else if (clr_grant) begin
      ram_addr  = clr_cnt;
      ram_we    = 1'b1;
      ram_wdata = clr_val;
    end else if (cpu_grant) begin
      ram_addr  = bus.cpu_addr;
      ram_we    = bus.cpu_we;
      ram_wdata = bus.cpu_wdata;
    end
  end

  // Read data is live from the RAM during the ack cycle, held afterwards.
  assign bus.cpu_ack   = (state == ACK);
  assign bus.cpu_rdata = ((state == ACK) && rd_q) ? ram_rdata : rdata_q;

  // CPU handshake FSM: grant -> one ack cycle -> idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_grant) begin
          state <= ACK;
          rd_q  <= !bus.cpu_we;
        end
        ACK: begin
          state <= IDLE;
          if (rd_q) rdata_q <= ram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display pipeline: prefetch -> char_next -> char_code at column boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr_q <= '0;
      disp_pend  <= 1'b0;
      char_next  <= '0;
      char_code  <= '0;
    end else begin
      ram_addr_q <= ram_addr;
      disp_pend  <= disp_slot;
      if (disp_pend) char_next <= ram_rdata;
      if (col_adv)   char_code <= char_next;
    end
  end

endmodule

// File: tb/tb_vga_text_arbiter.sv
// Directed + randomized bench for vga_text_arbiter with a behavioural
// text-RAM and a cell-level reference model of the display/CPU schedule.
module tb_vga_text_arbiter;
  localparam int FX = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] x_hi;
  logic [4:0] x_lo;
  logic [4:0] y_hi;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [7:0] char_code;
  logic       clr_start;
  logic [7:0] clr_fill;
  logic       clr_busy;

  vga_text_arbiter_if bus ();

  vga_text_arbiter #(.FETCH_X(FX), .H_LAST_HI(41), .H_LAST_LO(15)) dut (
    .clk(clk), .rst_n(rst_n), .x_hi(x_hi), .x_lo(x_lo), .y_hi(y_hi),
    .bus(bus), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .char_code(char_code), .clr_start(clr_start),
    .clr_fill(clr_fill), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  // 512x8 synchronous RAM, read-before-write, 1-cycle read latency.
  logic [7:0] mem [512];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int passed = 0;
  int total  = 0;
  logic [7:0] ref_mem [512];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] init_val(input int a);
    if (a == 'h065) return 8'h41;
    if (a == 'h040) return 8'h5A;
    return 8'((a * 7 + 3) & 'hFF);
  endfunction

  initial begin
    int miss, acks, bad, daddr;
    logic [8:0] a;
    logic       w, slot, adv, pend, done;
    logic [7:0] d, cc_exp, cn_exp, pd;
    logic [4:0] ry, rxl;
    logic [5:0] rxh;
    int phase;

    rst_n = 1'b0; x_hi = 0; x_lo = 0; y_hi = 5'd16;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    clr_start = 0; clr_fill = 0;
    repeat (3) step();
    chk("rst_ack", bus.cpu_ack, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_char", char_code, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    rst_n = 1'b1;
    step();

    // Preload every address through CPU writes during blank.
    miss = 0;
    for (int i = 0; i < 512; i++) begin
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 9'(i); bus.cpu_wdata = init_val(i);
      ref_mem[i] = init_val(i);
      step();
      if (bus.cpu_ack !== 1'b1) miss++;
      bus.cpu_req = 0; bus.cpu_we = 0;
      step();
    end
    chk("preload_acks", miss, 0);

    // Display prefetch of next cell and column advance.
    y_hi = 5'd3; x_hi = 6'd4; x_lo = 5'd8;
    #1;
    chk("t2_addr", ram_addr, 9'h065);
    chk("t2_we", ram_we, 0);
    step(); x_lo = 5'd9;
    step(); x_lo = 5'd31;
    #1;
    chk("t2_char_pre", char_code, 0);
    step();
    chk("t2_char", char_code, 8'h41);

    // Line wrap: last partial column fetches column 0.
    y_hi = 5'd2; x_hi = 6'd41; x_lo = 5'd8;
    #1;
    chk("t3_addr", ram_addr, 9'h040);
    chk("t3_we", ram_we, 0);
    step(); x_lo = 5'd9;
    step(); x_lo = 5'd15;
    #1;
    chk("t3_char_hold", char_code, 8'h41);
    step();
    chk("t3_char", char_code, 8'h5A);

    // CPU write then readback in vertical blank.
    y_hi = 5'd16; x_hi = 6'd0; x_lo = 5'd8;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 9'h1FF; bus.cpu_wdata = 8'hAA;
    #1;
    chk("t4_we", ram_we, 1);
    chk("t4_addr", ram_addr, 9'h1FF);
    chk("t4_wdata", ram_wdata, 8'hAA);
    chk("t4_ack_early", bus.cpu_ack, 0);
    step();
    chk("t4_ack", bus.cpu_ack, 1);
    bus.cpu_req = 0; bus.cpu_we = 0;
    ref_mem[9'h1FF] = 8'hAA;
    step();
    chk("t4_ack_drop", bus.cpu_ack, 0);
    bus.cpu_req = 1; bus.cpu_addr = 9'h1FF;
    #1;
    chk("t4_rd_addr", ram_addr, 9'h1FF);
    step();
    chk("t4_rd_ack", bus.cpu_ack, 1);
    chk("t4_rdata", bus.cpu_rdata, 8'hAA);
    bus.cpu_req = 0;
    step();
    chk("t4_rdata_hold", bus.cpu_rdata, 8'hAA);

    // Reset lands on the grant cycle of a read: access dropped.
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 9'h010; rst_n = 1'b0;
    step();
    chk("t1_ack", bus.cpu_ack, 0);
    chk("t1_we", ram_we, 0);
    chk("t1_char", char_code, 0);
    chk("t1_busy", clr_busy, 0);
    chk("t1_rdata", bus.cpu_rdata, 0);
    rst_n = 1'b1; bus.cpu_req = 0;
    acks = 0;
    repeat (3) begin
      step();
      if (bus.cpu_ack !== 1'b0) acks++;
    end
    chk("t1_no_ack", acks, 0);

    // CPU read colliding with the display slot waits one cycle.
    y_hi = 5'd1; x_hi = 6'd10; x_lo = 5'd8;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 9'h065;
    #1;
    chk("t5_disp_addr", ram_addr, 9'h02B);
    chk("t5_ack0", bus.cpu_ack, 0);
    cn_exp = ref_mem[9'h02B];
    step(); x_lo = 5'd9;
    #1;
    chk("t5_cpu_addr", ram_addr, 9'h065);
    chk("t5_ack1", bus.cpu_ack, 0);
    step();
    chk("t5_ack", bus.cpu_ack, 1);
    chk("t5_rdata", bus.cpu_rdata, 8'h41);
    bus.cpu_req = 0;
    step();

`ifdef VGA_TEXT_CLEAR_EN
    // Clear engine sweeps all 512 cells; stalled CPU read follows.
    y_hi = 5'd16; x_lo = 5'd0;
    clr_start = 1; clr_fill = 8'h20;
    step();
    clr_start = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 9'h123;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (i == 100) begin clr_start = 1; clr_fill = 8'h55; end
      else clr_start = 0;
      #1;
      if (!(ram_we === 1'b1 && ram_addr === 9'(i) && ram_wdata === 8'h20 &&
            clr_busy === 1'b1 && bus.cpu_ack === 1'b0)) bad++;
      step();
    end
    clr_start = 0;
    chk("t6_sweep", bad, 0);
    #1;
    chk("t6_busy_drop", clr_busy, 0);
    chk("t6_cpu_addr", ram_addr, 9'h123);
    step();
    chk("t6_ack", bus.cpu_ack, 1);
    chk("t6_rdata", bus.cpu_rdata, 8'h20);
    bus.cpu_req = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h20;
    step();
`else
    // Without the clear engine a start pulse has no effect.
    y_hi = 5'd16; x_lo = 5'd0;
    clr_start = 1; clr_fill = 8'h20;
    step();
    clr_start = 0;
    #1;
    chk("noclr_busy", clr_busy, 0);
    chk("noclr_we", ram_we, 0);
    step();
`endif

    // Randomized raster + CPU traffic against the cell-level model.
    cc_exp = 8'h00; pend = 0; pd = 8'h00;
    for (int n = 0; n < 300; n++) begin
      a = 9'($urandom_range(0, 511));
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      phase = 0; done = 0;
      for (int c = 0; c < 30 && !done; c++) begin
        ry  = 5'($urandom_range(0, 19));
        rxh = 6'($urandom_range(0, 41));
        rxl = ($urandom_range(0, 9) < 4) ? 5'(FX) : 5'($urandom_range(0, 31));
        y_hi = ry; x_hi = rxh; x_lo = rxl;
        bus.cpu_req = (phase == 0); bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
        #1;
        slot  = (int'(rxl) == FX) && (ry < 16) && (rxh < 31 || rxh == 41);
        daddr = (int'(ry) % 16) * 32 + ((rxh < 31) ? int'(rxh) + 1 : 0);
        chk("rnd_char", char_code, cc_exp);
        if (phase == 1) begin
          chk("rnd_ack", bus.cpu_ack, 1);
          if (!w) chk("rnd_rdata", bus.cpu_rdata, ref_mem[a]);
          done = 1;
        end else begin
          chk("rnd_noack", bus.cpu_ack, 0);
        end
        if (slot) begin
          chk("rnd_disp_addr", ram_addr, daddr);
          chk("rnd_disp_we", ram_we, 0);
        end else if (phase == 0) begin
          chk("rnd_cpu_addr", ram_addr, a);
          chk("rnd_cpu_we", ram_we, w);
          if (w) begin
            chk("rnd_cpu_wdata", ram_wdata, d);
            ref_mem[a] = d;
          end
          phase = 1;
        end else begin
          chk("rnd_idle_we", ram_we, 0);
        end
        adv = (ry < 16) && ((rxl == 5'd31 && rxh < 31) || (rxh == 41 && rxl == 5'd15));
        if (adv) cc_exp = cn_exp;
        if (pend) cn_exp = pd;
        pend = slot;
        pd   = ref_mem[daddr];
        step();
      end
      if (!done) chk("rnd_timeout", 0, 1);
    end
    bus.cpu_req = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
